ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit: owns the PC, reads 32-bit instructions from memory over a
//  valid/ready read channel (AR/R style), and hands {pc, inst} to the decoder through
//  a valid/ready pair. Sits between instruction memory and the decode stage, and takes
//  PC redirects from execute (branch/jal/jalr) and from the trap path (ecall -> mtvec).
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset
//  PC_STEP    4              sequential PC increment, bytes
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous reset, active low
//  araddr          out  32  fetch address (= pc)
//  arvalid         out  1   fetch request valid
//  arready         in   1   memory accepts request
//  rdata           in   32  returned instruction word
//  rresp           in   2   response code; 2'b00 = OK, other = error
//  rvalid          in   1   response valid
//  rready          out  1   unit accepts response
//  inst            out  32  instruction to decoder
//  inst_pc         out  32  PC of inst
//  inst_valid      out  1   {inst, inst_pc} valid
//  inst_ready      in   1   decoder accepts instruction
//  redirect_valid  in   1   one-cycle PC redirect strobe
//  redirect_pc     in   32  redirect target
//  halt            in   1   stop fetching (ebreak / npc halt)
//  fetch_err       out  1   sticky error: bad rresp or misaligned redirect
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, arvalid=0, rready=0, inst_valid=0,
//   inst=0, inst_pc=0, stale=0, fetch_err=0. All other state updates on posedge clk.
//  States: IDLE, REQ, WAIT, HOLD, ERR (2-bit encoding + ERR = 3 bits).
//  IDLE: arvalid=0. If !halt -> REQ next cycle.
//  REQ: arvalid=1, araddr=pc, held stable until arready (no retraction, even on redirect).
//   arvalid&arready -> WAIT.
//  WAIT: rready=1. On rvalid:
//   - rresp!=0 -> fetch_err=1, ERR.
//   - stale=1 -> drop rdata, stale<=0, -> REQ (or IDLE if halt).
//   - else inst<=rdata, inst_pc<=pc, inst_valid<=1, -> HOLD.
//  HOLD: inst_valid=1, inst/inst_pc stable until inst_ready. On handshake: pc<=pc+PC_STEP,
//   inst_valid<=0, -> REQ (IDLE if halt). Min latency req->inst_valid: 2 cycles with
//   arready and rvalid both in the cycle after issue; throughput 1 inst / 3 cycles max.
//  Redirect (redirect_valid=1, any state except ERR): pc<=redirect_pc.
//   - REQ without handshake, REQ with handshake, or WAIT without rvalid: stale<=1.
//   - WAIT with rvalid same cycle: response dropped, -> REQ.
//   - HOLD: inst_valid<=0 next cycle (held inst discarded) whether or not inst_ready;
//     redirect_pc wins over pc+PC_STEP; -> REQ.
//   - IDLE: pc updated, stays IDLE if halt.
//  Misaligned redirect (redirect_pc[1:0]!=0): fetch_err=1, ERR; pc still loaded.
//  halt: no new request issued; outstanding request completes (response consumed, a
//   non-stale inst is still presented in HOLD); then IDLE. halt deassert resumes at pc.
//  ERR: all valids 0, rready=1 (drains any late response); left only by reset.
//  pc arithmetic mod 2^32: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
//  Reset mid-transaction: outstanding memory response after reset is the memory's
//   problem; the unit restarts at RESET_PC.
// STRUCTURE
//  Shared package ifu_pkg: state enum/localparams (IDLE..ERR), RESP_OK=2'b00,
//   RESET_PC default. Single module; the pc/stale/hold registers are inline, no
//   sub-module is warranted.
// TESTING
//  1 reset release, arready=1, rvalid next cycle rdata=32'h00000413, inst_ready=1 ->
//    araddr=0x80000000, inst=0x00000413 inst_pc=0x80000000, then araddr=0x80000004.
//  2 inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc stable, no new arvalid.
//  3 redirect_pc=0x80000100 while in WAIT, rvalid 2 cycles later -> that rdata never
//    presented; next araddr=0x80000100.
//  4 redirect with inst_ready=1 in HOLD at pc=0x80000008 -> next araddr=redirect_pc,
//    not 0x8000000C.
//  5 rresp=2'b10 -> fetch_err=1, ERR, arvalid stays 0 forever; redirect_pc=0x80000002
//    from fresh reset -> fetch_err=1.
//  6 halt asserted in WAIT -> inst delivered, then IDLE with arvalid=0; deassert ->
//    araddr = next sequential pc.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state codes,
// response codes and reset defaults.
package ifu_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    localparam logic [1:0]  RESP_OK          = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam int unsigned DEFAULT_PC_STEP  = 4;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one read at a time over a
// valid/ready channel and presents {pc, inst} to decode.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_err
);

    logic [2:0]  state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] ar_addr, ar_addr_d;
    logic [31:0] inst_d, inst_pc_d;
    logic        inst_valid_d;
    logic        stale, stale_d;
    logic        err_d;
    logic [2:0]  resume_state;

    // The request address is latched separately from pc so a redirect never
    // changes araddr while arvalid is waiting for arready.
    assign araddr  = ar_addr;
    assign arvalid = (state == ST_REQ);
    assign rready  = (state == ST_WAIT) || (state == ST_ERR);

    assign resume_state = halt ? ST_IDLE : ST_REQ;

    // NOTE: every signal gets its hold value first so no branch leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        ar_addr_d    = ar_addr;
        inst_d       = inst;
        inst_pc_d    = inst_pc;
        inst_valid_d = inst_valid;
        stale_d      = stale;
        err_d        = fetch_err;

        case (state)
            ST_IDLE: begin
                if (!halt) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (arready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rvalid) begin
                    if (rresp != RESP_OK) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else if (stale || redirect_valid) begin
                        stale_d = 1'b0;
                        state_d = resume_state;
                    end else begin
                        inst_d       = rdata;
                        inst_pc_d    = pc;
                        inst_valid_d = 1'b1;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    pc_d         = pc + 32'(PC_STEP);
                    inst_valid_d = 1'b0;
                    state_d      = resume_state;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Redirect overrides the sequential pc; a request already in flight
        // is marked stale so its response is thrown away.
        if (redirect_valid && state != ST_ERR) begin
            pc_d = redirect_pc;
            if (state == ST_REQ || (state == ST_WAIT && !rvalid)) stale_d = 1'b1;
            if (state == ST_HOLD) begin
                inst_valid_d = 1'b0;
                state_d      = resume_state;
            end
            if (!is_aligned(redirect_pc)) begin
                err_d   = 1'b1;
                state_d = ST_ERR;
            end
        end

        if (state_d == ST_ERR) inst_valid_d = 1'b0;
        if (state_d == ST_REQ && state != ST_REQ) ar_addr_d = pc_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            ar_addr    <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            stale      <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            ar_addr    <= ar_addr_d;
            inst       <= inst_d;
            inst_pc    <= inst_pc_d;
            inst_valid <= inst_valid_d;
            stale      <= stale_d;
            fetch_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus a randomized
// phase checked against a transaction-level model of the delivered stream.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        fetch_err;

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Stimulus knobs (percent probabilities) and one-shot directed redirect.
    int          p_ar = 100, p_r = 100, p_ready = 100, p_redir = 0, p_halt = 0;
    bit          do_redirect = 0;
    logic [31:0] do_redirect_pc = '0;
    bit          resp_err = 0;

    // Reference model state: memory contents, one outstanding read, and the
    // program-order pc the decoder should see next.
    bit          pending = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] exp_pc = 32'h8000_0000;
    int          delivered = 0;
    bit          prev_ar_stall = 0, prev_hold_stall = 0;
    logic [31:0] prev_araddr, prev_inst, prev_inst_pc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[7:0], a[31:8]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, run the model on pre-edge values, step.
    task automatic tick();
        arready = ($urandom_range(99) < p_ar);
        rvalid  = pending && ($urandom_range(99) < p_r);
        rdata   = pending ? memfn(pend_addr) : $urandom;
        rresp   = resp_err ? 2'b10 : 2'b00;
        inst_ready = ($urandom_range(99) < p_ready);
        if (p_halt > 0 && $urandom_range(99) < p_halt) halt = ~halt;
        if (do_redirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = do_redirect_pc;
            do_redirect    = 0;
        end else if (p_redir > 0 && $urandom_range(99) < p_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h8000_0000 | (32'($urandom_range(1023)) << 2);
        end else begin
            redirect_valid = 1'b0;
        end

        if (prev_ar_stall) begin
            check("ar_hold_valid", {31'b0, arvalid}, 32'd1);
            check("ar_hold_addr", araddr, prev_araddr);
        end
        if (prev_hold_stall) begin
            check("hold_valid", {31'b0, inst_valid}, 32'd1);
            check("hold_inst", inst, prev_inst);
            check("hold_pc", inst_pc, prev_inst_pc);
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            check("deliver_pc", inst_pc, exp_pc);
            check("deliver_inst", inst, memfn(exp_pc));
            exp_pc += 32'd4;
            delivered++;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        if (rvalid && rready) pending = 0;
        if (arvalid && arready) begin
            pending   = 1;
            pend_addr = araddr;
        end
        prev_ar_stall   = arvalid && !arready;
        prev_araddr     = araddr;
        prev_hold_stall = inst_valid && !inst_ready && !redirect_valid;
        prev_inst       = inst;
        prev_inst_pc    = inst_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_arvalid(input string tag);
        for (int n = 0; n < 100 && !arvalid; n++) tick();
        check(tag, {31'b0, arvalid}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pending = 0;
        prev_ar_stall = 0;
        prev_hold_stall = 0;
        resp_err = 0;
        redirect_valid = 1'b0;
        halt = 1'b0;
        exp_pc = 32'h8000_0000;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_arvalid", {31'b0, arvalid}, 32'd0);
        check("rst_rready", {31'b0, rready}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        rst_n = 1'b1;

        // First fetch: 2-cycle request-to-instruction latency
        wait_arvalid("t1_arvalid");
        check("t1_araddr", araddr, 32'h8000_0000);
        tick();
        tick();
        check("t1_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("t1_inst", inst, 32'h0000_0413);
        check("t1_inst_pc", inst_pc, 32'h8000_0000);
        tick();
        check("t1_next_araddr", araddr, 32'h8000_0004);

        // Decoder stalls in HOLD
        p_ready = 0;
        tick();
        tick();
        check("t2_inst_valid", {31'b0, inst_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t2_no_arvalid", {31'b0, arvalid}, 32'd0);
            tick();
        end
        p_ready = 100;
        tick();

        // Redirect in HOLD beats pc+4
        tick();
        tick();
        check("t4_inst_pc", inst_pc, 32'h8000_0008);
        do_redirect = 1;
        do_redirect_pc = 32'h8000_0200;
        tick();
        check("t4_inst_dropped", {31'b0, inst_valid}, 32'd0);
        check("t4_arvalid", {31'b0, arvalid}, 32'd1);
        check("t4_araddr", araddr, 32'h8000_0200);

        // Redirect in WAIT: the late response must never reach decode
        tick();
        check("t3_rready", {31'b0, rready}, 32'd1);
        p_r = 0;
        do_redirect = 1;
        do_redirect_pc = 32'h8000_0100;
        tick();
        tick();
        p_r = 100;
        tick();
        check("t3_no_stale", {31'b0, inst_valid}, 32'd0);
        wait_arvalid("t3_arvalid");
        check("t3_araddr", araddr, 32'h8000_0100);
        tick();
        tick();
        check("t3_inst_pc", inst_pc, 32'h8000_0100);
        tick();

        // Halt during WAIT: instruction still delivered, then idle
        tick();
        halt = 1'b1;
        tick();
        check("t6_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("t6_inst_pc", inst_pc, 32'h8000_0104);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t6_idle_arvalid", {31'b0, arvalid}, 32'd0);
            tick();
        end
        halt = 1'b0;
        tick();
        check("t6_resume_araddr", araddr, 32'h8000_0108);

        // Redirect during an accepted request, to the top of the address space
        do_redirect = 1;
        do_redirect_pc = 32'hFFFF_FFFC;
        tick();
        tick();
        check("wrap_araddr", araddr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_next_araddr", araddr, 32'h0000_0000);

        // Randomized traffic against the stream model
        p_ar = 60; p_r = 60; p_ready = 70; p_redir = 5; p_halt = 8;
        delivered = 0;
        for (int i = 0; i < 4000; i++) tick();
        check("rand_progress", {31'b0, delivered > 200}, 32'd1);
        p_ar = 100; p_r = 100; p_ready = 100; p_redir = 0; p_halt = 0;
        halt = 1'b0;
        wait_arvalid("settle_arvalid");

        // Error response: sticky error, no more requests
        tick();
        resp_err = 1;
        tick();
        check("t5_fetch_err", {31'b0, fetch_err}, 32'd1);
        check("t5_inst_valid", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("t5_err_arvalid", {31'b0, arvalid}, 32'd0);
            tick();
        end
        check("t5_err_rready", {31'b0, rready}, 32'd1);

        // Misaligned redirect from fresh reset
        do_reset();
        rst_n = 1'b1;
        check("t5b_err_clear", {31'b0, fetch_err}, 32'd0);
        do_redirect = 1;
        do_redirect_pc = 32'h8000_0002;
        tick();
        check("t5b_fetch_err", {31'b0, fetch_err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t5b_arvalid", {31'b0, arvalid}, 32'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
